pc_src_sel_reg: RTL and testbench
=================================

// Module: pc_src_sel_reg
// PURPOSE
//   Parametrised N-source registered PC selector for the Fetch stage; generalises the 2:1 next-PC mux.
//   Source 0 is sequential PC (PC+4); sources 1..NUM_SRC-1 are redirects (branch, jump, exception),
//   with the highest index taking priority. Output is registered and held while Fetch is stalled.
//   A one-entry pending buffer captures any redirect that arrives during a stall, so it is applied later.
// PARAMETERS
//   WIDTH      32            data/PC width in bits
//   NUM_SRC    4             number of sources; legal range 2..16
//   RESET_VEC  32'h0000_0000 pc_out value after reset
//   CNT_W      16            width of redirect_cnt
//   SEL_W      localparam    $clog2(NUM_SRC); not overridable
// PORTS
//   clk          in   1              rising-edge clock
//   rst          in   1              synchronous reset, active-high
//   en           in   1              1 = advance, 0 = stall (hold)
//   src_vld      in   NUM_SRC        per-source valid; bit i refers to source i
//   src_data     in   NUM_SRC*WIDTH  flattened; source i = src_data[i*WIDTH +: WIDTH]
//   pc_out       out  WIDTH          registered selected PC
//   pc_out_vld   out  1              pc_out updated this cycle
//   sel_idx      out  SEL_W          index of the source that produced pc_out
//   redirect     out  1              pc_out came from a source with index >= 1
//   multi_hit    out  1              more than one candidate competed in the update cycle
//   pend_full    out  1              pending buffer occupied (state S_PEND)
//   redirect_cnt out  CNT_W          saturating count of redirect updates
// BEHAVIOUR
//   Reset (rst=1 at posedge, takes priority over everything): pc_out=RESET_VEC, pc_out_vld=0, sel_idx=0,
//     redirect=0, multi_hit=0, redirect_cnt=0, state=S_RUN, pending buffer cleared. Reset in S_PEND discards the pending entry.
//   Latency: one cycle from the src_vld/src_data sample to the pc_out update. No combinational input->output path.
//   Update rule for pc_out_vld, redirect and multi_hit: each is 1 only for the update cycle and 0 otherwise.
//   S_RUN, en=1:
//     - Winner = highest i with src_vld[i]. The register loads pc_out=src_data[i], sel_idx=i, pc_out_vld=1,
//       and redirect=(i!=0).
//     - If no src_vld bit is set: pc_out and sel_idx hold, pc_out_vld=0.
//     - multi_hit=1 when popcount(src_vld)>1.
//   S_RUN, en=0:
//     - All outputs hold; pc_out_vld=0.
//     - If any src_vld[i] with i>=1 is set: capture the highest such i and its data into the pending buffer,
//       then go to S_PEND. A src_vld[0]-only stall is dropped.
//   S_PEND, en=0:
//     - Hold outputs.
//     - A live redirect with index >= pend_idx overwrites the pending entry (newest wins on equal index).
//     - A lower-index live redirect is dropped.
//   S_PEND, en=1:
//     - Winner is the live redirect with index > pend_idx if present, else the pending entry.
//     - Source 0 is ignored in this cycle.
//     - Load the outputs as in S_RUN, set redirect=1, set multi_hit=1 if any live src_vld[i>=1] also competed,
//       clear the buffer, and go to S_RUN.
//   redirect_cnt: +1 on each cycle with pc_out_vld=1 and redirect=1; saturates at 2^CNT_W-1, never wraps.
//   X/Z on src_vld is undefined; bits of src_data whose valid is 0 are don't-care.
// TESTING
//   1. NUM_SRC=4; src_vld=0001, src_data[0]=0x0000_0004, en=1
//      -> next cycle pc_out=0x4, sel_idx=0, redirect=0, pc_out_vld=1.
//   2. src_vld=1011 in one cycle, src[3]=0xBFC0_0180, en=1
//      -> pc_out=0xBFC0_0180, sel_idx=3, multi_hit=1, redirect_cnt increments by 1.
//   3. en=0; pulse src_vld=0100 (src[2]=0x0040_0100) for one cycle; en=1 three cycles later
//      -> pend_full=1 during the stall, outputs held, then pc_out=0x0040_0100, sel_idx=2, pend_full=0.
//   4. S_PEND holding idx 2; stall cycle with src_vld=0010 -> pending entry unchanged;
//      release cycle with src_vld=1000, src[3]=0x8000_0080 -> pc_out=0x8000_0080, multi_hit=1.
//   5. Assert rst while in S_PEND -> pc_out=RESET_VEC, pend_full=0; on the next en=1 with src_vld=0
//      -> pc_out_vld=0, pc_out=RESET_VEC.
//   6. CNT_W=2; drive 5 consecutive redirects -> redirect_cnt reads 1,2,3,3,3 (saturates, no wrap).

Source files
------------

// File: rtl/pc_src_sel_reg.sv
// Registered N-source next-PC selector for Fetch. The highest-index valid source wins.
// A one-entry pending buffer holds a redirect that arrives during a stall until Fetch advances.
module pc_src_sel_reg #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_SRC   = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               CNT_W     = 16,
  localparam int              SEL_W     = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_SRC-1:0]       src_vld,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  output logic [WIDTH-1:0]         pc_out,
  output logic                     pc_out_vld,
  output logic [SEL_W-1:0]         sel_idx,
  output logic                     redirect,
  output logic                     multi_hit,
  output logic                     pend_full,
  output logic [CNT_W-1:0]         redirect_cnt
);

  typedef enum logic {S_RUN, S_PEND} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   pend_idx, pend_idx_nxt;
  logic [WIDTH-1:0]   pend_data, pend_data_nxt;
  logic [WIDTH-1:0]   pc_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic               vld_nxt, redir_nxt, multi_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic               any_vld, many_vld, red_any;
  logic [SEL_W-1:0]   win_idx;
  logic [WIDTH-1:0]   win_data;

  // Highest-index valid source; if it is nonzero it is also the highest live redirect.
  always_comb begin
    any_vld  = 1'b0;
    many_vld = 1'b0;
    win_idx  = '0;
    win_data = src_data[WIDTH-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_vld[i]) begin
        if (any_vld) many_vld = 1'b1;
        any_vld  = 1'b1;
        win_idx  = SEL_W'(i);
        win_data = src_data[i*WIDTH +: WIDTH];
      end
    end
    red_any = |src_vld[NUM_SRC-1:1];
  end

  always_comb begin
    state_nxt     = state;
    pend_idx_nxt  = pend_idx;
    pend_data_nxt = pend_data;
    pc_nxt        = pc_out;
    sel_nxt       = sel_idx;
    vld_nxt       = 1'b0;
    redir_nxt     = 1'b0;
    multi_nxt     = 1'b0;
    unique case (state)
      S_RUN: begin
        if (en) begin
          if (any_vld) begin
            pc_nxt    = win_data;
            sel_nxt   = win_idx;
            vld_nxt   = 1'b1;
            redir_nxt = (win_idx != '0);
            multi_nxt = many_vld;
          end
        end else if (red_any) begin
          pend_idx_nxt  = win_idx;
          pend_data_nxt = win_data;
          state_nxt     = S_PEND;
        end
      end
      S_PEND: begin
        if (en) begin
          if (red_any && (win_idx > pend_idx)) begin
            pc_nxt  = win_data;
            sel_nxt = win_idx;
          end else begin
            pc_nxt  = pend_data;
            sel_nxt = pend_idx;
          end
          vld_nxt       = 1'b1;
          redir_nxt     = 1'b1;
          multi_nxt     = red_any;
          pend_idx_nxt  = '0;
          pend_data_nxt = '0;
          state_nxt     = S_RUN;
        end else if (red_any && (win_idx >= pend_idx)) begin
          pend_idx_nxt  = win_idx;
          pend_data_nxt = win_data;
        end
      end
      default: state_nxt = S_RUN;
    endcase

    cnt_nxt = redirect_cnt;
    if (vld_nxt && redir_nxt && (redirect_cnt != CNT_MAX)) cnt_nxt = redirect_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      pend_idx     <= '0;
      pend_data    <= '0;
      pc_out       <= RESET_VEC;
      sel_idx      <= '0;
      pc_out_vld   <= 1'b0;
      redirect     <= 1'b0;
      multi_hit    <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state        <= state_nxt;
      pend_idx     <= pend_idx_nxt;
      pend_data    <= pend_data_nxt;
      pc_out       <= pc_nxt;
      sel_idx      <= sel_nxt;
      pc_out_vld   <= vld_nxt;
      redirect     <= redir_nxt;
      multi_hit    <= multi_nxt;
      redirect_cnt <= cnt_nxt;
    end
  end

  assign pend_full = (state == S_PEND);

endmodule

// File: tb/tb_pc_src_sel_reg.sv
// Bench for pc_src_sel_reg: directed scenarios plus random traffic against a behavioural model.
module tb_pc_src_sel_reg;
  localparam int          W   = 32;
  localparam int          N   = 4;
  localparam int          CW  = 2;
  localparam logic [31:0] RV  = 32'h1FC0_0000;
  localparam int          CMAX = 3;

  logic           clk = 1'b0;
  logic           rst, en;
  logic [N-1:0]   src_vld;
  logic [N*W-1:0] src_data;
  logic [W-1:0]   pc_out;
  logic           pc_out_vld, redirect, multi_hit, pend_full;
  logic [1:0]     sel_idx;
  logic [CW-1:0]  redirect_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc, m_pdata;
  int          m_sel, m_pidx, m_cnt;
  bit          m_vld, m_redir, m_multi, m_pend;

  pc_src_sel_reg #(.WIDTH(W), .NUM_SRC(N), .RESET_VEC(RV), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .src_vld(src_vld), .src_data(src_data),
    .pc_out(pc_out), .pc_out_vld(pc_out_vld), .sel_idx(sel_idx), .redirect(redirect),
    .multi_hit(multi_hit), .pend_full(pend_full), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input int i);
    return src_data[i*W +: W];
  endfunction

  // Reference: evaluates the selection rules directly on the sampled inputs.
  task automatic model_step();
    int hi;
    hi = -1;
    if (rst) begin
      m_pc = RV; m_sel = 0; m_vld = 0; m_redir = 0; m_multi = 0; m_cnt = 0; m_pend = 0;
      return;
    end
    for (int i = 0; i < N; i++) if (src_vld[i]) hi = i;
    m_vld = 0; m_redir = 0; m_multi = 0;
    if (!m_pend) begin
      if (en) begin
        if (hi >= 0) begin
          m_pc = data_of(hi); m_sel = hi; m_vld = 1;
          m_redir = (hi != 0);
          m_multi = ($countones(src_vld) > 1);
        end
      end else if (hi >= 1) begin
        m_pend = 1; m_pidx = hi; m_pdata = data_of(hi);
      end
    end else begin
      if (en) begin
        if (hi >= 1 && hi > m_pidx) begin
          m_pc = data_of(hi); m_sel = hi;
        end else begin
          m_pc = m_pdata; m_sel = m_pidx;
        end
        m_vld = 1; m_redir = 1; m_multi = (hi >= 1); m_pend = 0;
      end else if (hi >= 1 && hi >= m_pidx) begin
        m_pidx = hi; m_pdata = data_of(hi);
      end
    end
    if (m_vld && m_redir && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("pc_out", pc_out, m_pc);
    check("sel_idx", sel_idx, m_sel);
    check("pc_out_vld", pc_out_vld, m_vld);
    check("redirect", redirect, m_redir);
    check("multi_hit", multi_hit, m_multi);
    check("pend_full", pend_full, m_pend);
    check("redirect_cnt", redirect_cnt, m_cnt);
  endtask

  task automatic set_src(input int i, input logic [31:0] d);
    src_data[i*W +: W] = d;
  endtask

  task automatic drive(input logic r, input logic e, input logic [N-1:0] v);
    rst = r; en = e; src_vld = v;
  endtask

  initial begin
    m_pc = '0; m_pdata = '0; m_sel = 0; m_pidx = 0; m_cnt = 0;
    m_vld = 0; m_redir = 0; m_multi = 0; m_pend = 0;
    src_data = {$urandom, $urandom, $urandom, $urandom};
    drive(1, 0, '0);
    tick(); tick();
    check("reset_pc", pc_out, RV);

    // Sequential PC only.
    drive(0, 1, 4'b0001); set_src(0, 32'h0000_0004);
    tick();
    check("t1_pc", pc_out, 32'h4);
    check("t1_redir", redirect, 1'b0);

    // Three candidates, exception vector wins.
    drive(0, 1, 4'b1011); set_src(3, 32'hBFC0_0180);
    tick();
    check("t2_pc", pc_out, 32'hBFC0_0180);
    check("t2_multi", multi_hit, 1'b1);
    check("t2_cnt", redirect_cnt, 2'd1);

    // Redirect pulse during a stall is buffered and applied on release.
    drive(0, 0, 4'b0100); set_src(2, 32'h0040_0100);
    tick();
    check("t3_pend", pend_full, 1'b1);
    drive(0, 0, 4'b0000); tick(); tick();
    check("t3_hold", pc_out, 32'hBFC0_0180);
    drive(0, 1, 4'b0000); tick();
    check("t3_pc", pc_out, 32'h0040_0100);
    check("t3_sel", sel_idx, 2'd2);
    check("t3_pend_clr", pend_full, 1'b0);

    // Lower redirect dropped while pending; higher live redirect wins release.
    drive(0, 0, 4'b0100); set_src(2, 32'h0040_0200); tick();
    drive(0, 0, 4'b0010); set_src(1, 32'h1111_1110); tick();
    drive(0, 1, 4'b1000); set_src(3, 32'h8000_0080); tick();
    check("t4_pc", pc_out, 32'h8000_0080);
    check("t4_multi", multi_hit, 1'b1);

    // Pending entry applied when the equal-index overwrite is the newest.
    drive(0, 0, 4'b0100); set_src(2, 32'h0000_0a00); tick();
    drive(0, 0, 4'b0100); set_src(2, 32'h0000_0b00); tick();
    drive(0, 1, 4'b0011); tick();
    check("ovr_pc", pc_out, 32'h0000_0b00);

    // Reset while pending discards the entry.
    drive(0, 0, 4'b1000); set_src(3, 32'hDEAD_0000); tick();
    drive(1, 0, 4'b0000); tick();
    check("t5_pc", pc_out, RV);
    check("t5_pend", pend_full, 1'b0);
    drive(0, 1, 4'b0000); tick();
    check("t5_vld", pc_out_vld, 1'b0);
    check("t5_pc2", pc_out, RV);

    // Counter saturation.
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 4'b0010); set_src(1, 32'h100 + 32'(k)); tick();
      check("t6_cnt", redirect_cnt, (k < 3) ? k + 1 : 3);
    end

    for (int k = 0; k < 3000; k++) begin
      src_data = {$urandom, $urandom, $urandom, $urandom};
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), N'($urandom));
      if ($urandom_range(0, 3) == 0) src_vld = '0;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
